// File: rtl/isqrt_pkg.sv
// Shared sizing helpers and the per-stage bundle type for the radix-4 integer square-root pipe.
package isqrt_pkg;

  localparam int unsigned DefaultN = 32;

  function automatic int unsigned res_width(input int unsigned n);
    return n / 2;
  endfunction

  // One extra radix-4 digit of headroom keeps the trial subtraction from wrapping.
  function automatic int unsigned rem_width(input int unsigned n);
    return n / 2 + 2;
  endfunction

  function automatic int unsigned latency(input int unsigned n);
    return n / 2;
  endfunction

  localparam int unsigned DefResW = res_width(DefaultN);
  localparam int unsigned DefRemW = rem_width(DefaultN);

  typedef struct packed {
    logic                vld;
    logic [DefRemW-1:0]  rem;
    logic [DefResW-1:0]  root;
    logic [DefaultN-1:0] rad;
  } isqrt_stage_t;

endpackage

// File: rtl/isqrt_stage.sv
// One restoring radix-4 square-root iteration: brings down the next two radicand bits and
// decides one root bit. Purely combinational.
module isqrt_stage
  import isqrt_pkg::*;
#(
  parameter int unsigned N = 32
) (
  input  logic [rem_width(N)-1:0] rem_i,
  input  logic [res_width(N)-1:0] root_i,
  input  logic [N-1:0]            rad_i,
  output logic [rem_width(N)-1:0] rem_o,
  output logic [res_width(N)-1:0] root_o,
  output logic [N-1:0]            rad_o
);

  localparam int unsigned ResW = res_width(N);
  localparam int unsigned RemW = rem_width(N);
  localparam int unsigned WideW = RemW + 2;

  // Computed two bits wider than rem so no bit of rem_i is dropped before the compare.
  logic [WideW-1:0] r_shift;
  logic [WideW-1:0] trial;
  logic [WideW-1:0] diff;
  logic             fits;

  always_comb begin
    r_shift = {rem_i, rad_i[N-1:N-2]};
    trial   = WideW'({root_i, 2'b01});
    diff    = r_shift - trial;
    fits    = (r_shift >= trial);
    rem_o   = fits ? RemW'(diff) : RemW'(r_shift);
    root_o  = (root_i << 1) | ResW'(fits);
    rad_o   = rad_i << 2;
  end

endmodule

// File: rtl/isqrt_pipe.sv
// Fully pipelined floor(sqrt(x)): N/2 registered radix-4 stages, one operand per cycle,
// no backpressure. Only the valid chain and the final root are reset.
module isqrt_pipe
  import isqrt_pkg::*;
#(
  parameter int unsigned N = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    x_vld,
  input  logic [N-1:0]            x,
  output logic                    y_vld,
  output logic [res_width(N)-1:0] y
);

  localparam int unsigned ResW   = res_width(N);
  localparam int unsigned RemW   = rem_width(N);
  localparam int unsigned Stages = latency(N);

  // Index 0 is the pipe input; index i+1 is the register output of stage i.
  logic            vld_s  [Stages+1];
  logic [RemW-1:0] rem_s  [Stages+1];
  logic [ResW-1:0] root_s [Stages+1];
  logic [N-1:0]    rad_s  [Stages+1];

  assign vld_s[0]  = x_vld;
  assign rem_s[0]  = '0;
  assign root_s[0] = '0;
  assign rad_s[0]  = x;

  for (genvar i = 0; i < Stages; i++) begin : g_stage
    logic            vld_q;
    logic [RemW-1:0] rem_q, rem_d;
    logic [ResW-1:0] root_q, root_d;
    logic [N-1:0]    rad_q, rad_d;

    isqrt_stage #(
      .N(N)
    ) u_stage (
      .rem_i  (rem_s[i]),
      .root_i (root_s[i]),
      .rad_i  (rad_s[i]),
      .rem_o  (rem_d),
      .root_o (root_d),
      .rad_o  (rad_d)
    );

    always_ff @(posedge clk) begin
      if (!rst) begin
        vld_q <= 1'b0;
      end else begin
        vld_q <= vld_s[i];
      end

      // The last root register is the visible result, so it alone gets a reset value.
      if (!rst && (i == Stages - 1)) begin
        root_q <= '0;
      end else if (vld_s[i]) begin
        root_q <= root_d;
      end

      if (vld_s[i]) begin
        rem_q <= rem_d;
        rad_q <= rad_d;
      end
    end

    assign vld_s[i+1]  = vld_q;
    assign rem_s[i+1]  = rem_q;
    assign root_s[i+1] = root_q;
    assign rad_s[i+1]  = rad_q;
  end

  assign y_vld = vld_s[Stages];
  assign y     = root_s[Stages];

  // Final remainder and exhausted radicand carry no information.
  logic unused_tail;
  assign unused_tail = ^{rem_s[Stages], rad_s[Stages]};

endmodule
